// File: rtl/led_pkg.sv
// Shared definitions for the LED blink bank: channel mode encoding and its type.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF   = 2'd0;
  localparam mode_t MODE_ON    = 2'd1;
  localparam mode_t MODE_BLINK = 2'd2;
  localparam mode_t MODE_PULSE = 2'd3;

endpackage

// File: rtl/led_blink_bank_channel.sv
// One LED channel: holds mode, period, tick counter and LED level; advances on
// prescaler ticks and restarts on a qualified write (a write wins over a tick).
module led_channel
  import led_pkg::*;
#(
  parameter int PER_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr,
  input  mode_t            mode,
  input  logic [PER_W-1:0] period,
  output logic             led,
  output logic             busy
);

  mode_t            mode_q, mode_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;
  logic             last_tick;

  always_comb begin
    mode_d    = mode_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    led_d     = led_q;
    last_tick = (cnt_q == period_q - PER_W'(1));
    if (wr) begin
      mode_d   = mode;
      period_d = (period == '0) ? PER_W'(1) : period;
      cnt_d    = '0;
      led_d    = (mode != MODE_OFF);
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: begin
          if (last_tick) begin
            led_d = ~led_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + PER_W'(1);
          end
        end
        MODE_PULSE: begin
          // Pulse ends by falling back to OFF, which drops busy with the LED.
          if (last_tick) begin
            led_d  = 1'b0;
            mode_d = MODE_OFF;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + PER_W'(1);
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_OFF;
      period_q <= PER_W'(1);
      cnt_q    <= '0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
    end
  end

  assign led  = led_q;
  assign busy = (mode_q == MODE_PULSE);

endmodule

// File: rtl/led_blink_bank.sv
// Multi-channel LED driver: shared prescaler tick plus N_CH independently
// configured OFF/ON/BLINK/PULSE channels behind a single-cycle write port.
module led_blink_bank
  import led_pkg::*;
#(
  parameter int  CLK_HZ  = 50000000,
  parameter int  TICK_HZ = 1000,
  parameter int  N_CH    = 4,
  parameter int  PER_W   = 12,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  mode_t            wr_mode,
  input  logic [PER_W-1:0] wr_period,
  output logic [N_CH-1:0]  LED,
  output logic [N_CH-1:0]  busy,
  output logic             tick
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PS_W-1:0] presc_q, presc_d;
  logic            presc_wrap;
  logic [N_CH-1:0] wr_sel;

  always_comb begin
    presc_wrap = (presc_q == PS_W'(DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + PS_W'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  // With DIV == 1 the counter never leaves 0, so reset itself must hold tick low.
  assign tick = presc_wrap & ~(reset & (DIV == 1));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_sel[i] = wr_en && (wr_ch == CH_W'(i));

    led_channel #(
      .PER_W (PER_W)
    ) u_ch (
      .clk    (CLOCK_50),
      .reset  (reset),
      .tick   (tick),
      .wr     (wr_sel[i]),
      .mode   (wr_mode),
      .period (wr_period),
      .led    (LED[i]),
      .busy   (busy[i])
    );
  end

endmodule

// File: tb/tb_led_blink_bank.sv
// Directed bench for led_blink_bank with DIV=4, three channels, 4-bit periods.
// Expectations are cycle-tagged and checked by an independent negedge monitor.
module tb_led_blink_bank;
  import led_pkg::*;

  localparam int N_CH  = 3;
  localparam int PER_W = 4;
  localparam int W     = 7;  // observed vector {tick, busy[2:0], LED[2:0]}

  logic             CLOCK_50 = 1'b0;
  logic             reset    = 1'b1;
  logic             wr_en    = 1'b0;
  logic [1:0]       wr_ch    = '0;
  mode_t            wr_mode  = MODE_OFF;
  logic [PER_W-1:0] wr_period = '0;
  logic [N_CH-1:0]  LED;
  logic [N_CH-1:0]  busy;
  logic             tick;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  int           exp_cyc_q[$];
  string        name_q[$];

  logic [W-1:0] obs;
  logic [W-1:0] m_exp;
  logic [W-1:0] m_mask;
  int           m_cyc;
  string        m_name;

  led_blink_bank #(
    .CLK_HZ  (8),
    .TICK_HZ (2),
    .N_CH    (N_CH),
    .PER_W   (PER_W)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_mode   (wr_mode),
    .wr_period (wr_period),
    .LED       (LED),
    .busy      (busy),
    .tick      (tick)
  );

  // Clock and cycle counter: cyc = number of rising edges seen so far.
  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic expect_at(input int c, input string nm,
                           input logic [W-1:0] m, input logic [W-1:0] v);
    exp_cyc_q.push_back(c);
    name_q.push_back(nm);
    mask_q.push_back(m);
    exp_q.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic do_write(input int ch, input mode_t md, input int per);
    wr_en     = 1'b1;
    wr_ch     = 2'(ch);
    wr_mode   = md;
    wr_period = PER_W'(per);
    @(posedge CLOCK_50);
    #1;
    wr_en = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge CLOCK_50) begin
    obs = {tick, busy, LED};
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      m_cyc  = exp_cyc_q.pop_front();
      m_name = name_q.pop_front();
      m_mask = mask_q.pop_front();
      m_exp  = exp_q.pop_front();
      checks++;
      if (m_cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d",
                 m_name, m_cyc, cyc);
      end else if ((obs & m_mask) != (m_exp & m_mask)) begin
        errors++;
        $display("FAIL %s cyc=%0d: got {tick,busy,LED}=%b required %b (mask %b)",
                 m_name, cyc, obs & m_mask, m_exp & m_mask, m_mask);
      end
    end
  end

  initial begin
    // 1: reset for 3 edges, then tick every 4th cycle starting at cycle 4 after release
    for (int c = 1; c <= 2; c++) expect_at(c, "reset_hold", 7'h7F, 7'h00);
    for (int c = 3; c <= 14; c++)
      expect_at(c, "t1_tick_after_release", 7'h7F, (c % 4 == 2) ? 7'h40 : 7'h00);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step_to(15);

    // 2: ch1 ON then OFF
    expect_at(16, "t2_ch1_on", 7'h3F, 7'h02);
    do_write(1, MODE_ON, 0);
    expect_at(17, "t2_ch1_off", 7'h3F, 7'h00);
    do_write(1, MODE_OFF, 0);

    // 3 + 4: ch0 BLINK period 3, ch2 PULSE period 2
    expect_at(18, "t3_blink_start", 7'h3F, 7'h01);
    do_write(0, MODE_BLINK, 3);
    step(1);
    expect_at(20, "t4_pulse_start",     7'h7F, 7'h25);
    expect_at(26, "t4_pulse_last_high", 7'h7F, 7'h65);
    expect_at(27, "t3t4_toggle_and_end", 7'h7F, 7'h00);
    expect_at(31, "t4_pulse_stays_off", 7'h7F, 7'h00);
    expect_at(38, "t3_before_2nd_toggle", 7'h7F, 7'h40);
    expect_at(39, "t3_2nd_toggle",      7'h7F, 7'h01);
    expect_at(50, "t3_before_3rd_toggle", 7'h7F, 7'h41);
    expect_at(51, "t3_3rd_toggle",      7'h7F, 7'h00);
    do_write(2, MODE_PULSE, 2);
    step_to(52);

    // 5: period 0 -> 1, out-of-range write, write colliding with a tick
    expect_at(53, "t5_blink_p0_start",  7'h7F, 7'h01);
    expect_at(54, "t5_bad_ch_ignored",  7'h7F, 7'h41);
    expect_at(55, "t5_p0_toggle1",      7'h7F, 7'h00);
    expect_at(56, "t5_ch1_blink_p1",    7'h7F, 7'h02);
    expect_at(58, "t5_pre_collision",   7'h7F, 7'h42);
    expect_at(59, "t5_collision",       7'h7F, 7'h03);
    expect_at(62, "t5_after_collision", 7'h7F, 7'h43);
    expect_at(63, "t5_ch1_restarted",   7'h7F, 7'h02);
    expect_at(66, "t5_pre_ch1_toggle",  7'h7F, 7'h42);
    expect_at(67, "t5_ch1_toggle",      7'h7F, 7'h01);
    do_write(0, MODE_BLINK, 0);
    do_write(3, MODE_ON, 5);
    step(1);
    do_write(1, MODE_BLINK, 1);
    step(2);
    do_write(1, MODE_BLINK, 2);
    step_to(68);

    // 6: reset during BLINK and PULSE, prescaler restarts
    expect_at(69, "t6_pulse_start",    7'h24, 7'h24);
    expect_at(71, "t6_reset_clears",   7'h7F, 7'h00);
    expect_at(72, "t6_reset_held",     7'h7F, 7'h00);
    expect_at(73, "t6_no_early_tick",  7'h7F, 7'h00);
    expect_at(74, "t6_no_early_tick",  7'h7F, 7'h00);
    expect_at(75, "t6_first_tick",     7'h7F, 7'h40);
    expect_at(76, "t6_tick_one_cycle", 7'h7F, 7'h00);
    do_write(2, MODE_PULSE, 3);
    step(1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step_to(80);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expectations: %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_blink_bank.md
Name: led_blink_bank

Overview:
- Multi-channel LED driver; parametrised successor to the single fixed-rate board blinker.
- A shared prescaler divides CLOCK_50 into a one-cycle tick at TICK_HZ.
- Each of N_CH channels runs independently in one of four modes: OFF, ON, BLINK or PULSE, with a per-channel period counted in ticks.
- Channels are configured at run time through a single-cycle write port; outputs drive board LEDs directly.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1000, tick rate in Hz. DIV = CLK_HZ/TICK_HZ (integer floor), and DIV >= 1 is required.
- N_CH, 4, number of LED channels (>= 1).
- PER_W, 12, width of the per-channel period field.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  config write strobe, one cycle per write.
- wr_ch  in  max(1,$clog2(N_CH))  target channel index.
- wr_mode  in  2  mode: 0=OFF, 1=ON, 2=BLINK, 3=PULSE.
- wr_period  in  PER_W  period in ticks; 0 is treated as 1.
- LED  out  N_CH  registered LED outputs.
- busy  out  N_CH  high while that channel's mode is PULSE.
- tick  out  1  prescaler tick, high one cycle every DIV clocks.

Behaviour:
- Reset: reset, clock CLOCK_50, synchronous, active-high. While reset is high on a clock edge:
  - prescaler = 0, tick = 0;
  - every channel: mode = OFF, period = 1, cnt = 0;
  - LED = 0, busy = 0.
  - Reset overrides any simultaneous write. Reset mid-operation aborts blinks and pulses immediately.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - tick = (prescaler == DIV-1), decoded from the register (combinational from state).
  - Exact period is DIV clocks, with no off-by-one.
  - After reset release, the first tick is high in cycle DIV (counted from 1).
  - If DIV == 1, tick is high every cycle after reset.
- Write: on an edge where wr_en=1 and wr_ch < N_CH, the target channel loads mode, period = max(wr_period,1), cnt = 0.
  - LED on the next cycle: OFF→0, ON→1, BLINK→1, PULSE→1.
  - Writes with wr_ch >= N_CH are ignored, with no side effect.
  - A write to a channel already in the same mode still restarts it (cnt cleared, LED set per the list above).
- Write/tick collision: if a write and a tick hit the same edge, the written channel takes the write and ignores that tick. All other channels process the tick normally.
- OFF / ON: LED held at 0 or 1. cnt is not used.
- BLINK, on each tick:
  - if cnt == period-1: LED toggles, cnt = 0;
  - else cnt increments.
  - Each LED level therefore lasts period ticks; the full cycle is 2*period ticks.
- PULSE, on each tick:
  - if cnt == period-1: LED = 0, mode = OFF, cnt = 0;
  - else cnt increments.
  - The LED is high for exactly period ticks measured from the first tick after the write. The lead-in partial tick interval is not counted.
  - busy = (mode == PULSE); it drops on the same cycle as the LED.
- Widths:
  - cnt is PER_W bits and never exceeds period-1, so it cannot overflow.
  - The prescaler is max(1,$clog2(DIV)) bits.
- Latency: every LED and busy change is visible one clock after the causing edge (write or tick). No combinational path from inputs to LED.

Decomposition:
- Package led_pkg holds:
  - mode encoding constants MODE_OFF=0, MODE_ON=1, MODE_BLINK=2, MODE_PULSE=3;
  - a 2-bit mode typedef.
- Sub-module led_channel (one per channel via generate) holds mode, period, cnt and LED registers.
  - Inputs: clk, reset, tick, wr (already qualified by channel match), mode, period.
  - Outputs: led, busy.
- The prescaler and write-address decode stay in led_blink_bank.

Test Plan (CLK_HZ=8, TICK_HZ=2 → DIV=4; N_CH=3; PER_W=4):
1. Reset held 3 cycles, then released → LED=000 and busy=000. tick is high on cycles 4, 8, 12… after release; never two consecutive cycles.
2. Write ch1 ON → LED[1]=1 the next cycle. Write ch1 OFF → LED[1]=0 the next cycle. Other channels unchanged.
3. Write ch0 BLINK period=3 → LED[0]=1 the next cycle. It toggles on the 3rd, 6th, 9th… tick after the write, i.e. every 12 clocks.
4. Write ch2 PULSE period=2 → LED[2]=1 and busy[2]=1 the next cycle. Both drop on the cycle after the 2nd tick and stay 0; a later tick changes nothing.
5. Write ch0 BLINK period=0 → LED[0] toggles on every tick. A write with wr_ch=3 (>= N_CH) changes no output. A write to ch1 on a tick edge → ch1 restarts with cnt=0 while ch0 still toggles on that tick.
6. Reset asserted mid-BLINK and mid-PULSE → LED=000, busy=000 and tick=0 the next cycle. After release, the prescaler restarts: first tick in cycle 4 after release.
